// File: rtl/jk_drive_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : jk_drive_sequencer_if
//  Purpose  : Bundles the command push port, the JK drive outputs, the slave
//             feedback and the status outputs of jk_drive_sequencer.
//  Ports    : master - command source / flop model (drives cmd_valid, cmd,
//                      dwell, qs_in)
//             slave  - the sequencer (drives cmd_ready, j, k, busy, exp_q,
//                      mismatch, err_count, fifo_count)
//  Revision : 1.0 - initial release
// ============================================================================
interface jk_drive_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            cmd_valid;
  logic [1:0]      cmd;
  logic [3:0]      dwell;
  logic            cmd_ready;
  logic            j;
  logic            k;
  logic            qs_in;
  logic            busy;
  logic            exp_q;
  logic            mismatch;
  logic [CNTW-1:0] err_count;
  logic [CW-1:0]   fifo_count;

  modport master (
    output cmd_valid, cmd, dwell, qs_in,
    input  cmd_ready, j, k, busy, exp_q, mismatch, err_count, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd, dwell, qs_in,
    output cmd_ready, j, k, busy, exp_q, mismatch, err_count, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/jk_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : jk_drive_sequencer
//  Purpose  : Queues JK commands (hold/reset/set/toggle + dwell) in a small
//             FIFO, drives each onto j/k for dwell+1 cycles, predicts the
//             downstream flop state and checks the fed-back slave output.
//  Ports    : clk  - single rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - jk_drive_sequencer_if.slave (command push, j/k drive,
//                    qs_in feedback, busy/exp_q/mismatch/err_count/fifo_count)
//  Revision : 1.0 - initial release
// ============================================================================
module jk_drive_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input wire clk,
  input wire rst,
  jk_drive_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- FIFO ----
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q;
  logic          w_push, w_pop;
  logic [5:0]    w_head;

  assign w_push = bus.cmd_valid & ready_q;
  assign w_head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: occupancy alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {bus.cmd, bus.dwell};
  end

  // ready is registered from the next occupancy so it never depends on
  // cmd_valid within the same cycle. Pointers wrap naturally (DEPTH = 2^AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

  // ----------------------------------------------------------------- FSM ----
  logic [3:0] cnt_q;
  logic       w_drive_done;
  logic       w_check;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    w_pop        = 1'b0;
    w_drive_done = 1'b0;
    w_check      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          w_pop   = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == 4'd0) begin
          w_drive_done = 1'b1;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        w_check = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath ----
  logic [1:0]      cmd_cur_q;
  logic            tog_par_q;   // (dwell+1) mod 2 of the command in flight
  logic            j_q, k_q;
  logic            exp_q, known_q;
  logic [CNTW-1:0] err_q;
  logic            w_mismatch;

  // Compared against the already-updated prediction; reset suppresses the
  // check so an aborted CHECK never reports.
  assign w_mismatch = w_check & known_q & (bus.qs_in != exp_q) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      cmd_cur_q <= 2'b00;
      tog_par_q <= 1'b0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      exp_q     <= 1'b0;
      known_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      if (w_pop) begin
        cmd_cur_q <= w_head[5:4];
        tog_par_q <= ~w_head[0];
        cnt_q     <= w_head[3:0];
        j_q       <= w_head[5];   // set/toggle drive j
        k_q       <= w_head[4];   // reset/toggle drive k
      end else if (w_drive_done) begin
        j_q <= 1'b0;
        k_q <= 1'b0;
        case (cmd_cur_q)
          2'b01: begin exp_q <= 1'b0; known_q <= 1'b1; end
          2'b10: begin exp_q <= 1'b1; known_q <= 1'b1; end
          2'b11: exp_q <= exp_q ^ tog_par_q;
          default: ;
        endcase
      end else if (state_q == S_DRIVE) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (w_mismatch && (err_q != {CNTW{1'b1}})) err_q <= err_q + 1'b1;
    end
  end

  // ------------------------------------------------------------- outputs ----
  assign bus.cmd_ready  = ready_q;
  assign bus.fifo_count = count_q;
  assign bus.j          = j_q;
  assign bus.k          = k_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.exp_q      = exp_q;
  assign bus.mismatch   = w_mismatch;
  assign bus.err_count  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_drive_sequencer
//  Purpose  : Self-checking bench for jk_drive_sequencer: directed scenarios
//             plus random traffic, compared every cycle against a queue-based
//             behavioural model of the command stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jk_drive_sequencer;

  localparam int DEPTH = 4;
  localparam int CNTW  = 8;
  localparam int MAXE  = (1 << CNTW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [3:0] dwell = 4'd0;
  logic       qs_in = 1'b0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  jk_drive_sequencer_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd       = cmd;
  assign bus.dwell     = dwell;
  assign bus.qs_in     = qs_in;

  jk_drive_sequencer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------- reference model ----
  // A command lives in a queue until the sequencer is free; it then drives
  // for dwell+1 cycles, spends one cycle being checked, and one idle cycle
  // in which the next command is taken.
  typedef struct packed {
    logic [1:0] c;
    logic [3:0] d;
  } ent_t;

  ent_t mq[$];
  ent_t mcur = '0;
  int   mrem = 0;      // drive cycles remaining, including the current one
  bit   mchk = 1'b0;   // current cycle is the check cycle
  bit   mexp = 1'b0;
  bit   mknown = 1'b0;
  int   merr = 0;

  function automatic bit model_mismatch();
    return mchk && mknown && (qs_in != mexp) && !rst;
  endfunction

  function automatic void model_step();
    bit   do_push;
    ent_t e;
    if (rst) begin
      mq.delete();
      mrem = 0; mchk = 1'b0; mexp = 1'b0; mknown = 1'b0; merr = 0;
      return;
    end
    do_push = cmd_valid && (mq.size() < DEPTH);
    e.c = cmd;
    e.d = dwell;
    if (mchk) begin
      if (model_mismatch() && merr < MAXE) merr++;
      mchk = 1'b0;
    end else if (mrem > 0) begin
      if (mrem == 1) begin
        case (mcur.c)
          2'b01: begin mexp = 1'b0; mknown = 1'b1; end
          2'b10: begin mexp = 1'b1; mknown = 1'b1; end
          2'b11: mexp = mexp ^ bit'((int'(mcur.d) + 1) % 2);
          default: ;
        endcase
        mchk = 1'b1;
      end
      mrem--;
    end else if (mq.size() > 0) begin
      mcur = mq.pop_front();
      mrem = int'(mcur.d) + 1;
    end
    if (do_push) mq.push_back(e);
  endfunction

  // ------------------------------------------------------------ checking ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    chk("cmd_ready",  32'(bus.cmd_ready),  32'(mq.size() < DEPTH));
    chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    chk("busy",       32'(bus.busy),       32'((mrem > 0) || mchk));
    chk("j",          32'(bus.j),          32'((mrem > 0) && mcur.c[1]));
    chk("k",          32'(bus.k),          32'((mrem > 0) && mcur.c[0]));
    chk("exp_q",      32'(bus.exp_q),      32'(mexp));
    chk("mismatch",   32'(bus.mismatch),   32'(model_mismatch()));
    chk("err_count",  32'(bus.err_count),  32'(merr));
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later
  // and the model advances with the same inputs at the rising edge.
  task automatic cyc();
    #1;
    if (chk_en) compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------ stimulus ----
  int  n;
  int  acc;
  bit  saw_full;
  bit  mm_seen;

  initial begin
    // Power-up reset; the first checked cycle still has rst asserted.
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_en = 1'b1;
    do_reset();
    chk("reset_ready", 32'(bus.cmd_ready),  32'd1);
    chk("reset_fifo",  32'(bus.fifo_count), 32'd0);

    // Set with dwell 0, flop reports 1: no mismatch, prediction 1.
    qs_in = 1'b1;
    cmd_valid = 1'b1; cmd = 2'b10; dwell = 4'd0;
    cyc();
    cmd_valid = 1'b0;
    repeat (5) cyc();
    chk("set_exp_q", 32'(bus.exp_q),     32'd1);
    chk("set_err",   32'(bus.err_count), 32'd0);

    // Toggle with dwell 2 (odd drive length) flips prediction to 0; qs_in=1.
    cmd_valid = 1'b1; cmd = 2'b11; dwell = 4'd2;
    cyc();
    cmd_valid = 1'b0;
    repeat (7) cyc();
    chk("toggle_exp_q", 32'(bus.exp_q),     32'd0);
    chk("toggle_err",   32'(bus.err_count), 32'd1);

    // From reset, toggle and hold leave the state unknown: never checked.
    do_reset();
    mm_seen = 1'b0;
    cmd_valid = 1'b1; cmd = 2'b11; dwell = 4'($urandom_range(3, 0));
    cyc();
    cmd = 2'b00; dwell = 4'($urandom_range(3, 0));
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      qs_in = 1'($urandom_range(1, 0));
      #1;
      mm_seen = mm_seen | bus.mismatch;
      #0 cyc();
    end
    chk("unknown_no_mismatch", 32'(mm_seen),        32'd0);
    chk("unknown_err",         32'(bus.err_count),  32'd0);

    // Six pushes with cmd_valid held high against dwell=15 commands.
    do_reset();
    acc = 0; n = 0; saw_full = 1'b0;
    cmd_valid = 1'b1; dwell = 4'd15;
    cmd = 2'($urandom_range(3, 0));
    while (acc < 6 && n < 200) begin
      if (mq.size() < DEPTH) acc++;
      cyc();
      if (bus.fifo_count == 3'd4 && !bus.cmd_ready) saw_full = 1'b1;
      cmd = 2'($urandom_range(3, 0));
      qs_in = 1'($urandom_range(1, 0));
      n++;
    end
    cmd_valid = 1'b0;
    chk("burst_accept_timeout", 32'(acc >= 6), 32'd1);
    chk("burst_saw_full",       32'(saw_full), 32'd1);
    n = 0;
    while ((mq.size() > 0 || mrem > 0 || mchk) && n < 200) begin
      qs_in = 1'($urandom_range(1, 0));
      cyc();
      n++;
    end
    chk("burst_drain_timeout", 32'(n < 200), 32'd1);

    // Saturation: set commands with the flop stuck at 0 mismatch every time.
    do_reset();
    cmd_valid = 1'b1; cmd = 2'b10; dwell = 4'd0; qs_in = 1'b0;
    repeat (820) cyc();
    cmd_valid = 1'b0;
    repeat (4) cyc();
    chk("err_saturated", 32'(bus.err_count), 32'(MAXE));

    // Reset in the third DRIVE cycle with two entries still queued.
    do_reset();
    cmd_valid = 1'b1; cmd = 2'b11; dwell = 4'd5;
    repeat (3) cyc();
    cmd_valid = 1'b0;
    n = 0;
    while (mrem != 4 && n < 20) begin
      cyc();
      n++;
    end
    chk("abort_reach_drive", 32'(n < 20),         32'd1);
    chk("abort_queued",      32'(bus.fifo_count), 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy),       32'd0);
    chk("abort_j",    32'(bus.j),          32'd0);
    chk("abort_k",    32'(bus.k),          32'd0);
    chk("abort_fifo", 32'(bus.fifo_count), 32'd0);
    chk("abort_err",  32'(bus.err_count),  32'd0);
    chk("abort_exp",  32'(bus.exp_q),      32'd0);
    repeat (3) cyc();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(63, 0) == 0);
      cmd_valid = 1'($urandom_range(1, 0));
      cmd       = 2'($urandom_range(3, 0));
      dwell     = ($urandom_range(7, 0) == 0) ? 4'd15 : 4'($urandom_range(3, 0));
      qs_in     = 1'($urandom_range(1, 0));
      cyc();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
